// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of requester lanes, shared sink handshake and grant status for the
// four-way round-robin arbiter.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req;
  logic [4*WIDTH-1:0] data;
  logic [3:0]         last;
  logic [3:0]         ack;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic               out_ready;
  logic [1:0]         sel;
  logic               busy;

  // master: the arbiter itself; slave: requesters plus sink
  modport master (
    input  req, data, last, out_ready,
    output ack, out_valid, out_data, out_last, sel, busy
  );

  modport slave (
    output req, data, last, out_ready,
    input  ack, out_valid, out_data, out_last, sel, busy
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter driving one shared valid/ready channel;
// a grant lasts one transfer, cut short at MAX_BURST beats.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  mux4_rr_arbiter_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] sel_q;
  logic [1:0] last_grant;
  logic [3:0] beat_cnt;
  logic       beat_done;

  // First requester found scanning upward from the one after last_grant.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] lg);
    logic [1:0] idx;
    logic       found;
    rr_pick = lg;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = lg + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign bus.sel      = sel_q;
  assign bus.busy     = (state == GRANT);
  assign bus.out_data = bus.data[int'(sel_q)*WIDTH +: WIDTH];
  assign beat_done    = bus.out_valid & bus.out_ready;

  always_comb begin
    bus.out_valid = (state == GRANT) & bus.req[sel_q];
    bus.out_last  = bus.out_valid &
                    (bus.last[sel_q] | (beat_cnt == 4'(MAX_BURST - 1)));
    bus.ack       = 4'b0000;
    if (beat_done) bus.ack[sel_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel_q      <= 2'd0;
      last_grant <= 2'd3;
      beat_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req != 4'b0000) begin
            sel_q <= rr_pick(bus.req, last_grant);
            state <= GRANT;
          end
        end
        GRANT: begin
          // A dropped req simply stalls the grant; only accepted beats count.
          if (beat_done) begin
            if (bus.out_last) begin
              last_grant <= sel_q;
              beat_cnt   <= 4'd0;
              state      <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic against
// a transaction-level round-robin model.
module tb_mux4_rr_arbiter;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.WIDTH(W)) bus ();

  mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who holds the grant, who was served last, beats so far.
  bit m_grant;
  int m_sel, m_lastg, m_beats;
  int grants[$];
  int ack_seen[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_grant = 1'b0;
    m_sel   = 0;
    m_lastg = 3;
    m_beats = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_ack"},   32'(bus.ack),       32'd0);
    check_eq({tag, "_last"},  32'(bus.out_last),  32'd0);
    check_eq({tag, "_busy"},  32'(bus.busy),      32'd0);
    check_eq({tag, "_sel"},   32'(bus.sel),       32'd0);
  endtask

  task automatic do_reset();
    bus.req = 4'b0000; bus.last = 4'b0000; bus.out_ready = 1'b0; bus.data = '0;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive, compare against the model mid-cycle, advance the model.
  task automatic cycle(input logic [3:0] r, input logic [4*W-1:0] d,
                       input logic [3:0] l, input logic rdy);
    bit ev, el;
    logic [3:0]   ea;
    logic [W-1:0] ed;
    bus.req = r; bus.data = d; bus.last = l; bus.out_ready = rdy;
    @(negedge clk);
    ev = m_grant && r[m_sel];
    el = ev && (l[m_sel] || m_beats == MB - 1);
    ea = (ev && rdy) ? 4'(1 << m_sel) : 4'b0000;
    ed = d[m_sel*W +: W];
    check_eq("out_valid", 32'(bus.out_valid), 32'(ev));
    check_eq("out_last",  32'(bus.out_last),  32'(el));
    check_eq("ack",       32'(bus.ack),       32'(ea));
    check_eq("busy",      32'(bus.busy),      32'(m_grant));
    if (m_grant) check_eq("sel", 32'(bus.sel), 32'(m_sel));
    if (ev) check_eq("out_data", 32'(bus.out_data), 32'(ed));
    for (int i = 0; i < 4; i++) if (bus.ack[i]) ack_seen[i]++;
    if (!m_grant) begin
      if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++) begin
          if (!m_grant && r[(m_lastg + k) % 4]) begin
            m_sel   = (m_lastg + k) % 4;
            m_grant = 1'b1;
          end
        end
        grants.push_back(m_sel);
      end
    end else if (ev && rdy) begin
      if (el) begin
        m_lastg = m_sel;
        m_beats = 0;
        m_grant = 1'b0;
      end else begin
        m_beats++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*W-1:0] rnd_data();
    return {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
  endfunction

  initial begin
    int exp_order[6];
    int n0;
    exp_order = '{0, 1, 2, 3, 0, 1};
    reset = 1'b1;
    bus.req = 4'b0000; bus.data = '0; bus.last = 4'b0000; bus.out_ready = 1'b0;

    // Single one-beat transfer from requester 0
    do_reset();
    cycle(4'b0001, {24'h0, 8'hA5}, 4'b0001, 1'b1);
    cycle(4'b0001, {24'h0, 8'hA5}, 4'b0001, 1'b1);
    cycle(4'b0000, '0, 4'b0000, 1'b1);

    // All four requesting: fair rotation with one bubble per grant
    do_reset();
    grants.delete();
    for (int c = 0; c < 12; c++) cycle(4'b1111, rnd_data(), 4'b1111, 1'b1);
    check_eq("order_len", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check_eq("order", 32'(grants[i]), 32'(exp_order[i]));

    // Endless source on lane 2 is cut at MAX_BURST beats, then re-granted
    do_reset();
    grants.delete();
    ack_seen = '{0, 0, 0, 0};
    for (int c = 0; c < 6; c++) cycle(4'b0100, rnd_data(), 4'b0000, 1'b1);
    check_eq("burst_acks", 32'(ack_seen[2]), 32'(MB));
    cycle(4'b0100, rnd_data(), 4'b0000, 1'b1);
    check_eq("regrant_cnt", 32'(grants.size()), 32'd2);

    // Sink back-pressure: stable data, no acks, then exactly one ack
    do_reset();
    ack_seen = '{0, 0, 0, 0};
    cycle(4'b0001, {24'h0, 8'h3C}, 4'b0000, 1'b0);
    for (int c = 0; c < 5; c++) cycle(4'b0001, {24'h0, 8'h3C}, 4'b0000, 1'b0);
    check_eq("stall_acks", 32'(ack_seen[0]), 32'd0);
    cycle(4'b0001, {24'h0, 8'h3C}, 4'b0000, 1'b1);
    check_eq("release_acks", 32'(ack_seen[0]), 32'd1);

    // Source pauses mid-burst, then resumes at the same beat count
    do_reset();
    cycle(4'b0001, rnd_data(), 4'b0000, 1'b1);
    cycle(4'b0001, rnd_data(), 4'b0000, 1'b1);
    for (int c = 0; c < 3; c++) cycle(4'b1110, rnd_data(), 4'b0000, 1'b1);
    for (int c = 0; c < 4; c++) cycle(4'b0001, rnd_data(), 4'b0000, 1'b1);

    // Asynchronous reset between edges with two beats already sent
    do_reset();
    for (int c = 0; c < 3; c++) cycle(4'b0001, rnd_data(), 4'b0000, 1'b1);
    bus.req = 4'b0001;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.req = 4'b0000;
    @(posedge clk);
    #1;
    grants.delete();
    cycle(4'b1000, rnd_data(), 4'b1000, 1'b1);
    cycle(4'b1000, rnd_data(), 4'b1000, 1'b1);
    check_eq("post_rst_grant", 32'(grants.size() > 0 ? grants[0] : -1), 32'd3);

    // Random traffic
    do_reset();
    ack_seen = '{0, 0, 0, 0};
    for (int c = 0; c < 600; c++)
      cycle(4'($urandom), rnd_data(), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    n0 = ack_seen[0] + ack_seen[1] + ack_seen[2] + ack_seen[3];
    check_eq("random_progress", 32'(n0 > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
